// File: rtl/key_filter_multi.sv
// ----------------------------------------------------------------------------
// key_filter_multi
//   N-channel push-button debouncer. Each channel has a 2-FF synchroniser, a
//   debounce counter and a four-state filter FSM. The outputs are a clean level
//   plus one-cycle press and release strobes. Keys are active-low and idle high.
//
// Optional feature macro: KEY_FILTER_MULTI_LONG_PRESS_EN
//   When defined, each channel has a 32-bit hold counter that runs while the
//   key is down. key_repeat pulses at LONG_CYC hold cycles and every REPEAT_CYC
//   cycles after that. When undefined, key_repeat is constant 0.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   key_in       raw asynchronous keys, 0 = pressed
//   key_state    debounced level, 0 = pressed
//   key_press    one-cycle strobe on an accepted press
//   key_release  one-cycle strobe on an accepted release
//   key_repeat   long-press/repeat strobe (0 unless the feature is enabled)
// ----------------------------------------------------------------------------
module key_filter_multi #(
   parameter int unsigned N_KEYS       = 4,
   parameter int unsigned CNT_W        = 20,
   parameter int unsigned DEBOUNCE_CYC = 1_000_000,
   parameter int unsigned LONG_CYC     = 50_000_000,
   parameter int unsigned REPEAT_CYC   = 10_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat
);

   typedef enum logic [1:0] {
      StIdle,
      StPressFlt,
      StDown,
      StRelFlt
   } state_t;

   // The filter accepts a level on the cycle its counter would reach this value,
   // so the strobe appears DEBOUNCE_CYC clocks after key_s first changes.
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYC - 1);

   logic [N_KEYS-1:0] sync1_q;
   logic [N_KEYS-1:0] sync2_q;

   // Synchronisers reset to the idle (released) level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= key_in;
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             rel_q, rel_d;
      logic             key_s;

      assign key_s = sync2_q[i];

      always_comb begin
         state_d = state_q;
         cnt_d   = '0;
         level_d = level_q;
         press_d = 1'b0;
         rel_d   = 1'b0;
         cnt_inc = cnt_q + 1'b1;
         unique case (state_q)
            StIdle: begin
               if (!key_s) begin
                  state_d = StPressFlt;
               end
            end
            StPressFlt: begin
               if (key_s) begin
                  state_d = StIdle;
               end else if (cnt_inc == CntLast) begin
                  state_d = StDown;
                  level_d = 1'b0;
                  press_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            StDown: begin
               if (key_s) begin
                  state_d = StRelFlt;
               end
            end
            StRelFlt: begin
               if (!key_s) begin
                  state_d = StDown;
               end else if (cnt_inc == CntLast) begin
                  state_d = StIdle;
                  level_d = 1'b1;
                  rel_d   = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
         end
      end

      assign key_state[i]   = level_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = rel_q;

`ifdef KEY_FILTER_MULTI_LONG_PRESS_EN
      localparam logic [31:0] HoldLast   = 32'(LONG_CYC - 1);
      localparam logic [31:0] HoldReload = 32'(LONG_CYC - REPEAT_CYC);

      logic [31:0] hold_q, hold_d;
      logic        rep_q, rep_d;

      // Counts only while staying in DOWN; any other state clears it, so the
      // press cycle itself always starts from zero and never repeats.
      always_comb begin
         hold_d = '0;
         rep_d  = 1'b0;
         if (state_q == StDown && !key_s) begin
            if (hold_q == HoldLast) begin
               hold_d = HoldReload;
               rep_d  = 1'b1;
            end else begin
               hold_d = hold_q + 32'd1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
         end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
         end
      end

      assign key_repeat[i] = rep_q;
`else
      assign key_repeat[i] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_key_filter_multi.sv
module tb_key_filter_multi;

   localparam int unsigned NK = 4;
   localparam int unsigned CW = 8;
   localparam int unsigned DB = 16;
   localparam int unsigned LC = 100;
   localparam int unsigned RC = 20;
   localparam int          LAT = DB + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [NK-1:0] key_in;
   logic [NK-1:0] key_state;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;
   logic [NK-1:0] key_repeat;

   key_filter_multi #(
      .N_KEYS      (NK),
      .CNT_W       (CW),
      .DEBOUNCE_CYC(DB),
      .LONG_CYC    (LC),
      .REPEAT_CYC  (RC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in),
      .key_state  (key_state),
      .key_press  (key_press),
      .key_release(key_release),
      .key_repeat (key_repeat)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 = press, 1 = release, 2 = repeat
   typedef struct {
      int ch;
      int kind;
      int at;
   } ev_t;

   ev_t sb[$];
   int  errors = 0;
   int  checks = 0;

   task automatic expect_ev(input int ch, input int kind, input int at);
      ev_t e;
      e.ch   = ch;
      e.kind = kind;
      e.at   = at;
      sb.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Strobe monitor: each observed strobe pops the scoreboard front.
   always @(negedge clk) begin
      ev_t e;
      logic s;
      if (sb.size() > 0) begin
         checks++;
         assert (sb[0].at >= cyc)
         else begin
            errors++;
            $error("FAIL missed_ev: ch=%0d kind=%0d observed=none expected_at=%0d now=%0d",
                   sb[0].ch, sb[0].kind, sb[0].at, cyc);
            void'(sb.pop_front());
         end
      end
      for (int ch = 0; ch < NK; ch++) begin
         for (int k = 0; k < 3; k++) begin
            s = (k == 0) ? key_press[ch] : (k == 1) ? key_release[ch] : key_repeat[ch];
            if (s) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $error("FAIL unexpected_ev: observed ch=%0d kind=%0d at %0d expected=none",
                         ch, k, cyc);
               end else begin
                  e = sb.pop_front();
                  chk("ev_ch", ch, e.ch);
                  chk("ev_kind", k, e.kind);
                  chk("ev_cycle", cyc, e.at);
               end
            end
         end
      end
      if (|{key_press, key_release}) begin
         chk("press_rel_excl", 32'(key_press & key_release), 32'd0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      int p;
      rst    = 1'b1;
      key_in = '0;

      // Reset with keys pressed: outputs must be idle.
      wait_cyc(3);
      chk("rst_state", 32'(key_state), 32'hF);
      chk("rst_press", 32'(key_press), 32'h0);
      chk("rst_release", 32'(key_release), 32'h0);
      chk("rst_repeat", 32'(key_repeat), 32'h0);

      // Key 0 still held after reset release: fresh press after LAT clocks.
      rst    = 1'b0;
      key_in = 4'b1110;
      expect_ev(0, 0, cyc + LAT);
      wait_cyc(LAT - 1);
      chk("pre_press_state", 32'(key_state), 32'hF);
      wait_cyc(5);
      chk("k0_down_state", 32'(key_state), 32'hE);

      // Bouncy press on key 1: runs shorter than DB never get accepted.
      for (int i = 0; i < 50; i++) begin
         key_in[1] = ~key_in[1];
         wait_cyc($urandom_range(1, 15));
      end
      chk("bounce_no_change", 32'(key_state), 32'hE);
      key_in[1] = 1'b0;
      expect_ev(1, 0, cyc + LAT);
      wait_cyc(LAT + 4);
      chk("k1_down_state", 32'(key_state), 32'hC);

      // Short glitch on key 2.
      key_in[2] = 1'b0;
      wait_cyc(10);
      key_in[2] = 1'b1;
      wait_cyc(LAT + 4);
      chk("glitch_state", 32'(key_state), 32'hC);

      // Bouncy release on key 1.
      for (int i = 0; i < 20; i++) begin
         key_in[1] = ~key_in[1];
         wait_cyc($urandom_range(1, 15));
      end
      chk("rel_bounce_state", 32'(key_state), 32'hC);
      key_in[1] = 1'b1;
      expect_ev(1, 1, cyc + LAT);
      wait_cyc(LAT + 4);
      chk("k1_up_state", 32'(key_state), 32'hE);

      // Release key 0, then press all four on the same clock.
      key_in = 4'hF;
      expect_ev(0, 1, cyc + LAT);
      wait_cyc(LAT + 4);
      chk("all_up_state", 32'(key_state), 32'hF);
      key_in = 4'h0;
      c = cyc;
      for (int ch = 0; ch < NK; ch++) expect_ev(ch, 0, c + LAT);
      wait_cyc(LAT + 4);
      chk("all_down_state", 32'(key_state), 32'h0);

      // Release all, then reset mid-REL_FLT: no release strobes.
      key_in = 4'hF;
      wait_cyc(8);
      chk("mid_relflt_state", 32'(key_state), 32'h0);
      rst = 1'b1;
      wait_cyc(2);
      chk("mid_rst_state", 32'(key_state), 32'hF);
      rst = 1'b0;
      wait_cyc(LAT + 6);
      chk("post_rst_state", 32'(key_state), 32'hF);

`ifdef KEY_FILTER_MULTI_LONG_PRESS_EN
      // Long press on key 3: repeats at hold cycles 100, 120, ..., 180.
      key_in[3] = 1'b0;
      p = cyc + LAT;
      expect_ev(3, 0, p);
      for (int k = int'(LC); k < 200; k += int'(RC)) expect_ev(3, 2, p + k);
      wait_cyc(p + 195 - cyc);
      chk("long_hold_state", 32'(key_state), 32'h7);
      key_in[3] = 1'b1;
      expect_ev(3, 1, cyc + LAT);
      wait_cyc(LAT + 4 + int'(RC));
      chk("long_up_state", 32'(key_state), 32'hF);
`else
      // Long hold without the feature: no repeat strobes at all.
      key_in[3] = 1'b0;
      p = cyc + LAT;
      expect_ev(3, 0, p);
      wait_cyc(p + 195 - cyc);
      chk("hold_state", 32'(key_state), 32'h7);
      key_in[3] = 1'b1;
      expect_ev(3, 1, cyc + LAT);
      wait_cyc(LAT + 4);
      chk("hold_up_state", 32'(key_state), 32'hF);
`endif

      chk("repeat_idle", 32'(key_repeat), 32'h0);
      wait_cyc(2);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
